irq_controller: RTL and testbench

Interrupt source side of the processor's interrupt handshake. It edge-detects and latches external interrupt requests, applies a mask, and picks the highest-priority pending source. It raises InterruptIn to the multicycle control unit and holds it until the control unit acknowledges with EPCWrite. It then reports the in-handler status and handler vector until the handler returns.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_edge_detect.sv | 45 ++++
 rtl/irq_controller.sv | 95 +++++++++
 tb/tb_irq_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
// Build option: IRQ_SYNC_EN adds a 2-flop synchronizer per request line.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irqState_t;

    localparam int unsigned      DEF_NUM_SRC      = 4;
    localparam logic [15:0]      DEF_HANDLER_BASE = 16'h0100;
    localparam logic [15:0]      DEF_VEC_STRIDE   = 16'h0008;

    // Lowest set index wins; supports up to 8 sources.
    function automatic logic [2:0] prioEncode(input logic [7:0] req);
        logic       found;
        logic [2:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// One interrupt source: optional synchronizer, rising-edge detect, pending latch.
// Build option: IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the detector.
module irq_edge_detect (
    input  logic clk,
    input  logic clrN,
    input  logic irqReq,
    input  logic clr,
    output logic pending
);

    logic sampled;
    logic irqPrev;

`ifdef IRQ_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-stage synchronizer; resets high so a line already high is not an edge.
    always_ff @(posedge clk) begin
        if (!clrN) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= irqReq;
            sync2 <= sync1;
        end
    end

    assign sampled = sync2;
`else
    assign sampled = irqReq;
`endif

    // Edge detect and pending latch; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!clrN) begin
            irqPrev <= 1'b1;
            pending <= 1'b0;
        end else begin
            irqPrev <= sampled;
            pending <= (sampled & ~irqPrev) | (pending & ~clr);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt source side of the processor handshake: latches edges, masks,
// prioritises, and runs the IDLE/REQUEST/SERVICE handshake with the control unit.
// Build option: IRQ_SYNC_EN (see irq_edge_detect) adds input synchronizers.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned          NUM_SRC      = DEF_NUM_SRC,
    parameter int unsigned          ADDR_W       = 16,
    parameter logic [ADDR_W-1:0]    HANDLER_BASE = ADDR_W'(DEF_HANDLER_BASE),
    parameter logic [ADDR_W-1:0]    VEC_STRIDE   = ADDR_W'(DEF_VEC_STRIDE)
) (
    input  logic                        CLK,
    input  logic                        CLR_N,
    input  logic [NUM_SRC-1:0]          IrqReq,
    input  logic [NUM_SRC-1:0]          IrqMask,
    input  logic                        EPCWrite,
    input  logic                        ReturnFromInt,
    output logic                        InterruptIn,
    output logic                        InterruptHandler,
    output logic [$clog2(NUM_SRC)-1:0]  IrqCause,
    output logic [ADDR_W-1:0]           HandlerAddr,
    output logic [NUM_SRC-1:0]          Pending
);

    localparam int unsigned CAUSE_W = $clog2(NUM_SRC);

    irqState_t            state;
    logic [NUM_SRC-1:0]   ackClr;
    logic [7:0]           reqPad;
    logic [CAUSE_W-1:0]   winIdx;
    logic [ADDR_W-1:0]    nextAddr;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
        irq_edge_detect uEdge (
            .clk     (CLK),
            .clrN    (CLR_N),
            .irqReq  (IrqReq[g]),
            .clr     (ackClr[g]),
            .pending (Pending[g])
        );
    end

    assign reqPad   = 8'(Pending & IrqMask);
    assign winIdx   = CAUSE_W'(prioEncode(reqPad));
    assign nextAddr = HANDLER_BASE + ADDR_W'(winIdx) * VEC_STRIDE;

    // Clear the serviced source's pending bit when the control unit acknowledges.
    always_comb begin
        ackClr = '0;
        if (state == REQUEST && EPCWrite) begin
            ackClr[IrqCause] = 1'b1;
        end
    end

    // Handshake FSM; cause and vector are latched on entry to REQUEST only.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state            <= IDLE;
            InterruptIn      <= 1'b0;
            InterruptHandler <= 1'b0;
            IrqCause         <= '0;
            HandlerAddr      <= HANDLER_BASE;
        end else begin
            case (state)
                IDLE: begin
                    if (reqPad != '0) begin
                        state       <= REQUEST;
                        InterruptIn <= 1'b1;
                        IrqCause    <= winIdx;
                        HandlerAddr <= nextAddr;
                    end
                end
                REQUEST: begin
                    if (EPCWrite) begin
                        state            <= SERVICE;
                        InterruptIn      <= 1'b0;
                        InterruptHandler <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (ReturnFromInt) begin
                        state            <= IDLE;
                        InterruptHandler <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    InterruptIn      <= 1'b0;
                    InterruptHandler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: the stimulus process advances a
// behavioural model and queues the expected outputs; a monitor compares them.
module tb_irq_controller;

    logic        CLK = 1'b0;
    logic        CLR_N = 1'b0;
    logic [3:0]  IrqReq = 4'b0010;
    logic [3:0]  IrqMask = 4'hF;
    logic        EPCWrite = 1'b0;
    logic        ReturnFromInt = 1'b0;
    logic        InterruptIn;
    logic        InterruptHandler;
    logic [1:0]  IrqCause;
    logic [15:0] HandlerAddr;
    logic [3:0]  Pending;

    irq_controller #(
        .NUM_SRC      (4),
        .ADDR_W       (16),
        .HANDLER_BASE (16'h0100),
        .VEC_STRIDE   (16'h0008)
    ) dut (
        .CLK              (CLK),
        .CLR_N            (CLR_N),
        .IrqReq           (IrqReq),
        .IrqMask          (IrqMask),
        .EPCWrite         (EPCWrite),
        .ReturnFromInt    (ReturnFromInt),
        .InterruptIn      (InterruptIn),
        .InterruptHandler (InterruptHandler),
        .IrqCause         (IrqCause),
        .HandlerAddr      (HandlerAddr),
        .Pending          (Pending)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ii;
        logic        ih;
        logic [1:0]  cause;
        logic [15:0] addr;
        logic [3:0]  pend;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nFailed   = 0;

    // Reference model: what the interrupt handshake looks like after each edge.
    bit [3:0]    mPend;
    bit [3:0]    mPrev;
    bit          mReq;
    bit          mHdl;
    int unsigned mCause;
    logic [15:0] mAddr;

    logic [3:0]  curReq;
    logic [3:0]  curMask;

    task automatic step(input logic c, input logic [3:0] r, input logic [3:0] m,
                        input logic e, input logic ret, input string name);
        bit [3:0] edges;
        bit [3:0] active;
        exp_t     x;
        @(posedge CLK);
        #2;
        CLR_N = c; IrqReq = r; IrqMask = m; EPCWrite = e; ReturnFromInt = ret;
        curReq = r; curMask = m;
        if (!c) begin
            mPend = '0; mPrev = '1; mReq = 0; mHdl = 0; mCause = 0; mAddr = 16'h0100;
        end else begin
            edges  = r & ~mPrev;
            active = mPend & m;
            if (!mReq && !mHdl) begin
                for (int i = 3; i >= 0; i--) begin
                    if (active[i]) begin
                        mReq   = 1;
                        mCause = i;
                        mAddr  = 16'h0100 + 16'(8 * i);
                    end
                end
            end else if (mReq) begin
                if (e) begin
                    mPend[mCause] = 0;
                    mReq = 0;
                    mHdl = 1;
                end
            end else if (ret) begin
                mHdl = 0;
            end
            mPend = mPend | edges;
            mPrev = r;
        end
        x.ii = mReq; x.ih = mHdl; x.cause = 2'(mCause); x.addr = mAddr;
        x.pend = mPend; x.name = name;
        expQ.push_back(x);
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) step(1, curReq, curMask, 0, 0, name);
    endtask

    task automatic runUntilReq(input string name);
        int budget = 20;
        while (!mReq && budget > 0) begin
            step(1, curReq, curMask, 0, 0, name);
            budget--;
        end
        if (!mReq) begin
            nFailed++;
            $display("FAIL %s: no request within cycle budget", name);
        end
    endtask

    // Monitor: one registered output snapshot per cycle, compared in order.
    always @(posedge CLK) begin
        exp_t x;
        #1;
        if (expQ.size() > 0) begin
            x = expQ.pop_front();
            nCompared++;
            if ({InterruptIn, InterruptHandler, IrqCause, HandlerAddr, Pending} !==
                {x.ii, x.ih, x.cause, x.addr, x.pend}) begin
                nFailed++;
                $display("FAIL %s @%0t: got ii=%b ih=%b cause=%0d addr=%h pend=%b, want ii=%b ih=%b cause=%0d addr=%h pend=%b",
                         x.name, $time, InterruptIn, InterruptHandler, IrqCause, HandlerAddr, Pending,
                         x.ii, x.ih, x.cause, x.addr, x.pend);
            end
        end
    end

    initial begin
        curReq = 4'b0010; curMask = 4'hF;

        // Reset held with a line already high: no request after release.
        step(0, 4'b0010, 4'hF, 0, 0, "rst");
        step(0, 4'b0010, 4'hF, 0, 0, "rst");
        idle(4, "rstHold");

        // Single request on source 2, then ack and return.
        step(1, 4'b0110, 4'hF, 0, 0, "single");
        runUntilReq("singleReq");
        idle(2, "singleHold");
        step(1, curReq, curMask, 1, 0, "singleAck");
        step(1, curReq, curMask, 1, 0, "epcInSvc");
        idle(1, "singleSvc");
        step(1, curReq, curMask, 0, 1, "singleRet");
        step(1, curReq, curMask, 0, 1, "retInIdle");

        // Priority: sources 3 and 1 together; 1 first, 3 queued.
        step(1, 4'b0000, 4'hF, 0, 0, "prioLow");
        step(1, 4'b1010, 4'hF, 0, 0, "prio");
        runUntilReq("prioReq1");
        step(1, curReq, curMask, 1, 1, "epcRetTogether");
        idle(1, "prioSvc");
        step(1, curReq, curMask, 0, 1, "prioRet");
        runUntilReq("prioReq3");
        step(1, curReq, curMask, 1, 0, "prioAck3");
        step(1, curReq, curMask, 0, 1, "prioRet3");

        // Mask: source 0 pends while masked, requests once unmasked.
        step(1, 4'b0001, 4'b1110, 0, 0, "mask");
        idle(3, "maskHold");
        step(1, curReq, 4'hF, 0, 0, "unmask");
        runUntilReq("unmaskReq");
        step(1, curReq, curMask, 1, 0, "maskAck");
        step(1, curReq, curMask, 0, 1, "maskRet");

        // Set/clear collision on source 2, plus mask drop during REQUEST.
        step(1, 4'b0000, 4'hF, 0, 0, "colLow");
        step(1, 4'b0100, 4'hF, 0, 0, "colEdge");
        runUntilReq("colReq");
        step(1, 4'b0000, 4'b1011, 0, 0, "maskDropInReq");
        step(1, 4'b0100, 4'hF, 1, 0, "collide");
        idle(2, "colSvc");
        step(1, curReq, curMask, 0, 1, "colRet");
        runUntilReq("colReReq");
        step(1, curReq, curMask, 1, 0, "colAck2");
        step(1, curReq, curMask, 0, 1, "colRet2");

        // Reset during SERVICE with source 3 pending.
        step(1, 4'b0000, 4'hF, 0, 0, "rsLow");
        step(1, 4'b0001, 4'hF, 0, 0, "rsEdge0");
        runUntilReq("rsReq");
        step(1, 4'b1001, 4'hF, 0, 0, "rsEdge3");
        step(1, curReq, curMask, 1, 0, "rsAck");
        step(0, curReq, curMask, 0, 0, "rstSvc");
        idle(3, "afterRst");

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            logic [3:0] m;
            r = curReq;
            m = curMask;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            if ($urandom_range(9) == 0) m = 4'($urandom);
            step(($urandom_range(59) != 0), r, m,
                 ($urandom_range(2) == 0), ($urandom_range(3) == 0), "rand");
        end

        @(posedge CLK);
        @(posedge CLK);
        #3;
        if (expQ.size() != 0) begin
            nFailed++;
            $display("FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
